// File: rtl/timer_pkg.sv
// Shared encodings for the timer count-enable generator: source selects,
// external edge modes and the prescaler tap positions.
package timer_pkg;

    localparam logic [2:0] CKS_STOP  = 3'd0;
    localparam logic [2:0] CKS_P2    = 3'd1;
    localparam logic [2:0] CKS_P8    = 3'd2;
    localparam logic [2:0] CKS_P32   = 3'd3;
    localparam logic [2:0] CKS_P64   = 3'd4;
    localparam logic [2:0] CKS_P1024 = 3'd5;
    localparam logic [2:0] CKS_P8192 = 3'd6;
    localparam logic [2:0] CKS_EXT   = 3'd7;

    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_BOTH = 2'd2;
    localparam logic [1:0] EDGE_CASC = 2'd3;

    localparam int NUM_TAPS = 6;

    // Element t is log2 of the divider for tap t; tap 0 is P/2, tap 5 is P/8192.
    localparam logic [NUM_TAPS-1:0][3:0] TAP_K =
        {4'd13, 4'd10, 4'd6, 4'd5, 4'd3, 4'd1};

endpackage

// File: rtl/timer_ext_edge_sync.sv
// Synchronises one asynchronous timer pin into clk and reports single-cycle
// rising and falling events from the synchronised level.
module timer_ext_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Runs regardless of channel selection so a later switch to external sees no stale edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin_i};
            r_hist <= w_s;
        end
    end

    assign rise_o = w_s & ~r_hist;
    assign fall_o = ~w_s & r_hist;

endmodule

// File: rtl/timer_count_enable_gen.sv
// Timer clock-select stage: free-running prescaler taps, external pin edges or
// cascade overflow are muxed per channel into a registered count-enable pulse.
module timer_count_enable_gen
    import timer_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int PRESC_W     = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH*3-1:0]   cks_i,
    input  logic [NUM_CH*2-1:0]   edge_sel_i,
    input  logic [NUM_CH-1:0]     tmci_i,
    input  logic [NUM_CH-1:0]     cascade_ovf_i,
    output logic [NUM_CH-1:0]     count_en_o,
    output logic [NUM_TAPS-1:0]   presc_tick_o
);

    logic [PRESC_W-1:0]  r_presc;
    logic [NUM_TAPS-1:0] w_tick;
    logic [NUM_CH-1:0]   w_casc;

    always_ff @(posedge clk) begin
        if (rst) r_presc <= '0;
        else     r_presc <= r_presc + 1'b1;
    end

    for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
        localparam int K = int'(TAP_K[t]);
        assign w_tick[t] = &r_presc[K-1:0];
    end

    assign presc_tick_o = w_tick;

    // Channel 0 has no predecessor, so its cascade input is masked off.
    localparam logic [NUM_CH-1:0] CASC_MASK = ~NUM_CH'(1);
    assign w_casc = cascade_ovf_i & CASC_MASK;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [2:0] w_cks;
        logic [1:0] w_edge;
        logic       w_rise;
        logic       w_fall;
        logic       w_sel;
        logic       r_en;

        assign w_cks  = cks_i[3*ch +: 3];
        assign w_edge = edge_sel_i[2*ch +: 2];

        timer_ext_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst   (rst),
            .pin_i (tmci_i[ch]),
            .rise_o(w_rise),
            .fall_o(w_fall)
        );

        always_comb begin
            w_sel = 1'b0;
            case (w_cks)
                CKS_STOP:  w_sel = 1'b0;
                CKS_P2:    w_sel = w_tick[0];
                CKS_P8:    w_sel = w_tick[1];
                CKS_P32:   w_sel = w_tick[2];
                CKS_P64:   w_sel = w_tick[3];
                CKS_P1024: w_sel = w_tick[4];
                CKS_P8192: w_sel = w_tick[5];
                CKS_EXT: begin
                    case (w_edge)
                        EDGE_RISE: w_sel = w_rise;
                        EDGE_FALL: w_sel = w_fall;
                        EDGE_BOTH: w_sel = w_rise | w_fall;
                        EDGE_CASC: w_sel = w_casc[ch];
                        default:   w_sel = 1'b0;
                    endcase
                end
                default:   w_sel = 1'b0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) r_en <= 1'b0;
            else     r_en <= w_sel;
        end

        assign count_en_o[ch] = r_en;
    end

endmodule

// File: tb/tb_timer_count_enable_gen.sv
// Directed bench for timer_count_enable_gen: a per-cycle vector table for the
// P/8 start-up case plus hand-written multi-cycle sequences for the corners.
module tb_timer_count_enable_gen;

  logic       clk;
  logic       rst;
  logic [5:0] cks;
  logic [3:0] edge_sel;
  logic [1:0] tmci;
  logic [1:0] casc;
  logic [1:0] count_en;
  logic [5:0] presc_tick;

  int n_checks = 0;
  int n_errors = 0;

  timer_count_enable_gen #(
    .NUM_CH(2),
    .SYNC_STAGES(2),
    .PRESC_W(13)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cks_i        (cks),
    .edge_sel_i   (edge_sel),
    .tmci_i       (tmci),
    .cascade_ovf_i(casc),
    .count_en_o   (count_en),
    .presc_tick_o (presc_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] cks;
    logic [3:0] edge_sel;
    logic [1:0] tmci;
    logic [1:0] casc;
    logic [1:0] exp_en;
    logic [5:0] exp_tick;
  } vec_t;

  vec_t vecs [25];

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Leaves the bench positioned in cycle 0 (first cycle with rst low).
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check("reset_en", 32'(count_en), 32'd0);
    check("reset_tick", 32'(presc_tick), 32'd0);
    rst = 1'b0;
  endtask

  task automatic ext_run(input string name, input logic [1:0] es, input int exp_a, input int exp_b);
    int pulses;
    pulses = 0;
    edge_sel[1:0] = es;
    for (int rel = -5; rel < 15; rel++) begin
      tmci[0] = (rel >= 0 && rel < 5);
      check(name, 32'(count_en[0]), 32'(rel == exp_a || rel == exp_b));
      if (count_en[0]) pulses++;
      step();
    end
    check({name, "_count"}, 32'(pulses), (exp_b >= 0) ? 32'd2 : 32'd1);
  endtask

  initial begin
    int pulses;
    int en_cnt [2];
    int tick_cnt [6];
    int first_8192;

    rst = 1'b1; cks = '0; edge_sel = '0; tmci = '0; casc = '0;

    // Test 1: P/8 on channel 0, table-driven from reset release
    for (int c = 0; c < 25; c++) begin
      vecs[c].cks      = {3'd0, 3'd2};
      vecs[c].edge_sel = 4'd0;
      vecs[c].tmci     = 2'b00;
      vecs[c].casc     = 2'b00;
      vecs[c].exp_en   = {1'b0, (c % 8 == 0) && (c != 0)};
      vecs[c].exp_tick = {4'b0000, (c % 8 == 7), (c % 2 == 1)};
    end
    cks = vecs[0].cks;
    do_reset();
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      cks = vecs[c].cks; edge_sel = vecs[c].edge_sel;
      tmci = vecs[c].tmci; casc = vecs[c].casc;
      check($sformatf("t1_en_c%0d", c), 32'(count_en), 32'(vecs[c].exp_en));
      check($sformatf("t1_tick_c%0d", c), 32'(presc_tick), 32'(vecs[c].exp_tick));
      if (count_en[0]) pulses++;
      step();
    end
    check("t1_pulses", 32'(pulses), 32'd3);

    // Test 2: ch0 P/2, ch1 P/8192 across a full prescaler wrap
    cks = {3'd6, 3'd1};
    do_reset();
    en_cnt = '{0, 0};
    tick_cnt = '{0, 0, 0, 0, 0, 0};
    first_8192 = -1;
    for (int c = 0; c <= 16384; c++) begin
      for (int b = 0; b < 2; b++) if (count_en[b]) en_cnt[b]++;
      for (int b = 0; b < 6; b++) if (presc_tick[b]) tick_cnt[b]++;
      if (presc_tick[5] && first_8192 < 0) first_8192 = c;
      if (c == 8192 || c == 16384)
        check($sformatf("t2_wrap_c%0d", c), 32'(count_en), 32'd3);
      step();
    end
    check("t2_ch0_pulses", 32'(en_cnt[0]), 32'd8192);
    check("t2_ch1_pulses", 32'(en_cnt[1]), 32'd2);
    check("t2_tick_p2", 32'(tick_cnt[0]), 32'd8192);
    check("t2_tick_p8", 32'(tick_cnt[1]), 32'd2048);
    check("t2_tick_p32", 32'(tick_cnt[2]), 32'd512);
    check("t2_tick_p64", 32'(tick_cnt[3]), 32'd256);
    check("t2_tick_p1024", 32'(tick_cnt[4]), 32'd16);
    check("t2_tick_p8192", 32'(tick_cnt[5]), 32'd2);
    check("t2_first_8192", 32'(first_8192), 32'd8191);

    // Test 3: external pin on ch0, rising / falling / both
    cks = {3'd0, 3'd7}; edge_sel = 4'd0; tmci = 2'b00;
    do_reset();
    ext_run("t3_rise", 2'd0, 3, -100);
    ext_run("t3_fall", 2'd1, 8, -100);
    ext_run("t3_both", 2'd2, 3, 8);

    // Test 4a: pin high through reset yields one rising event
    cks = {3'd7, 3'd0}; edge_sel = 4'd0; tmci = 2'b10;
    do_reset();
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("t4a_c%0d", c), 32'(count_en[1]), 32'(c == 3));
      if (count_en[1]) pulses++;
      step();
    end
    check("t4a_pulses", 32'(pulses), 32'd1);

    // Test 4b: switch to external while pin already high gives no pulse
    cks = 6'd0; tmci = 2'b10;
    do_reset();
    for (int c = 0; c < 10; c++) step();
    cks = {3'd7, 3'd0}; edge_sel = 4'd0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("t4b_c%0d", c), 32'(count_en[1]), 32'd0);
      step();
    end
    tmci = 2'b00;

    // Test 5: cascade on both channels, only ch1 responds
    cks = {3'd7, 3'd7}; edge_sel = 4'b1111;
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      casc = (c == 40) ? 2'b11 : 2'b00;
      check($sformatf("t5_ch1_c%0d", c), 32'(count_en[1]), 32'(c == 41));
      check($sformatf("t5_ch0_c%0d", c), 32'(count_en[0]), 32'd0);
      step();
    end
    casc = 2'b00;

    // Test 6a: reset at presc=5 restarts the P/8 period
    cks = {3'd0, 3'd2}; edge_sel = 4'd0;
    do_reset();
    for (int c = 0; c < 5; c++) step();
    check("t6_presc5_tick", 32'(presc_tick), 32'd1);
    rst = 1'b1;
    step();
    check("t6_rst_en", 32'(count_en), 32'd0);
    check("t6_rst_tick", 32'(presc_tick), 32'd0);
    rst = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      check($sformatf("t6_c%0d", c), 32'(count_en[0]), 32'(c == 8));
      step();
    end

    // Test 6b: reset in the cycle a P/8 tick is pending drops that pulse
    do_reset();
    for (int c = 0; c < 7; c++) step();
    check("t6b_tick_pending", 32'(presc_tick[1]), 32'd1);
    rst = 1'b1;
    step();
    check("t6b_no_pulse", 32'(count_en), 32'd0);
    rst = 1'b0;

    // Test 7: select change drops a pending old-source tick
    cks = {3'd0, 3'd1};
    do_reset();
    for (int c = 0; c < 5; c++) step();
    check("t7_p2_pending", 32'(presc_tick[0]), 32'd1);
    cks = {3'd0, 3'd2};
    step();
    check("t7_dropped", 32'(count_en[0]), 32'd0);
    step();
    step();
    check("t7_new_source", 32'(count_en[0]), 32'd1);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
